// File: rtl/plab4_net_pkg.sv
// Shared definitions for the ring network router: output port indices and
// the ring routing function used by the input controls.
package plab4_net_pkg;

    // Output port indices of a router, also the bit positions in request vectors.
    typedef enum logic [1:0] {
        WEST = 2'd0,
        TERM = 2'd1,
        EAST = 2'd2
    } port_e;

    // Number of router hops to the destination going east, folded onto the
    // ring. Zero hops delivers locally, up to half the ring goes east (ties
    // included), anything further goes west.
    function automatic port_e route(
        input logic [1:0] dest,
        input int         router_id,
        input int         num_routers
    );
        int fwd;
        fwd = ((int'(dest) - router_id) % num_routers + num_routers) % num_routers;
        if (fwd == 0) begin
            return TERM;
        end else if (fwd <= num_routers / 2) begin
            return EAST;
        end else begin
            return WEST;
        end
    endfunction

endpackage

// File: rtl/plab4_net_InputQueue2.sv
// Two-entry registered FIFO with no bypass: an enqueued entry reaches the
// head on the following cycle, and the queue reports not-ready while full
// even if the head leaves in the same cycle.
module plab4_net_InputQueue2 #(
    parameter int p_nbits = 45
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_enq_val,
    output logic               o_enq_rdy,
    input  logic [p_nbits-1:0] i_enq_msg,
    output logic               o_deq_val,
    input  logic               i_deq_rdy,
    output logic [p_nbits-1:0] o_deq_msg
);

    logic [p_nbits-1:0] r_entries [2];
    logic               r_head;
    logic               r_tail;
    logic [1:0]         r_count;

    logic               w_enq;
    logic               w_deq;

    assign o_enq_rdy = (r_count < 2'd2);
    assign o_deq_val = (r_count != 2'd0);
    assign o_deq_msg = r_entries[r_head];

    assign w_enq = i_enq_val && o_enq_rdy;
    assign w_deq = o_deq_val && i_deq_rdy;

    // Pointer and occupancy update; reset wins over any enqueue or dequeue.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_enq) r_tail <= ~r_tail;
            if (w_deq) r_head <= ~r_head;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage write at the tail.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; an entry is only read
        // once r_count says it is valid, so clearing it would be wasted logic.
        if (w_enq) r_entries[r_tail] <= i_enq_msg;
    end

endmodule

// File: rtl/plab4_net_router_input_ctrl_sep.sv
// Router input control: buffers incoming {msg, domain} pairs, routes the
// head entry around the ring and requests the chosen output port until it
// is granted.
// Optional feature: define PLAB4_NET_ROUTER_IN_DOMAIN_CHECK_EN to drop
// secure (domain=1) messages headed for the terminal while the terminal
// only accepts domain 0, counting them in drop_count.
module plab4_net_router_input_ctrl_sep
    import plab4_net_pkg::*;
#(
    parameter int p_msg_nbits   = 44,
    parameter int p_dest_lsb    = 40,
    parameter int p_router_id   = 0,
    parameter int p_num_routers = 4
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_msg_nbits-1:0] in_msg,
    input  logic                   in_domain,

    output logic                   reqs_p0,
    output logic                   reqs_p1,
    output logic                   reqs_p2,
    output logic                   reqs_p0_domain,
    output logic                   reqs_p1_domain,
    output logic                   reqs_p2_domain,
    input  logic                   grants_p0,
    input  logic                   grants_p1,
    input  logic                   grants_p2,

    output logic [p_msg_nbits-1:0] head_msg,
    output logic                   head_domain,

    input  logic                   term_domain,
    output logic [7:0]             drop_count
);

    localparam int c_entry_nbits = p_msg_nbits + 1;

    logic [c_entry_nbits-1:0] w_head_entry;
    logic                     w_head_val;
    logic                     w_deq;
    logic                     w_drop;
    logic [1:0]               w_dest;
    port_e                    w_route;
    logic [2:0]               w_reqs;
    logic [2:0]               w_grants;
    logic                     w_req_domain;

    plab4_net_InputQueue2 #(
        .p_nbits (c_entry_nbits)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .i_enq_val (in_val),
        .o_enq_rdy (in_rdy),
        .i_enq_msg ({in_domain, in_msg}),
        .o_deq_val (w_head_val),
        .i_deq_rdy (w_deq),
        .o_deq_msg (w_head_entry)
    );

    assign head_msg    = w_head_entry[p_msg_nbits-1:0];
    assign head_domain = w_head_entry[p_msg_nbits];

    assign w_dest  = head_msg[p_dest_lsb +: 2];
    assign w_route = route(w_dest, p_router_id, p_num_routers);

`ifdef PLAB4_NET_ROUTER_IN_DOMAIN_CHECK_EN
    logic [7:0] r_drop_count;

    assign w_drop     = w_head_val && (w_route == TERM) && head_domain && !term_domain;
    assign drop_count = r_drop_count;

    // Count dropped heads, saturating at the top of the 8-bit range.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count <= 8'd0;
        end else if (w_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end
`else
    logic w_unused;

    assign w_drop     = 1'b0;
    assign drop_count = 8'd0;
    assign w_unused   = term_domain;
`endif

    // One-hot request toward the routed port whenever a non-dropped head waits.
    always_comb begin
        // NOTE: defaulting every always_comb output first keeps a missed
        // branch from inferring a latch.
        w_reqs = 3'b000;
        if (w_head_val && !w_drop) begin
            w_reqs[w_route] = 1'b1;
        end
    end

    assign w_grants     = {grants_p2, grants_p1, grants_p0};
    assign w_deq        = (|(w_reqs & w_grants)) || w_drop;
    assign w_req_domain = w_head_val && head_domain;

    assign reqs_p0 = w_reqs[WEST];
    assign reqs_p1 = w_reqs[TERM];
    assign reqs_p2 = w_reqs[EAST];

    assign reqs_p0_domain = w_req_domain;
    assign reqs_p1_domain = w_req_domain;
    assign reqs_p2_domain = w_req_domain;

endmodule

// File: tb/tb_plab4_net_router_input_ctrl_sep.sv
// Bench for the router input control (router id 0, ring of 4). Stimulus
// pushes the expected {port, domain, msg} of each accepted message into a
// scoreboard; a monitor pops and compares whenever a request is granted.
// Directed state checks cover reset, back-pressure and the domain drop.
module tb_plab4_net_router_input_ctrl_sep;

    localparam int MSG_W = 44;

    typedef struct {
        logic [1:0]       port;
        logic             dom;
        logic [MSG_W-1:0] msg;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_val;
    logic             in_rdy;
    logic [MSG_W-1:0] in_msg;
    logic             in_domain;
    logic             reqs_p0, reqs_p1, reqs_p2;
    logic             reqs_p0_domain, reqs_p1_domain, reqs_p2_domain;
    logic [2:0]       grants;
    logic [MSG_W-1:0] head_msg;
    logic             head_domain;
    logic             term_domain;
    logic [7:0]       drop_count;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    plab4_net_router_input_ctrl_sep #(
        .p_msg_nbits   (44),
        .p_dest_lsb    (40),
        .p_router_id   (0),
        .p_num_routers (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_val         (in_val),
        .in_rdy         (in_rdy),
        .in_msg         (in_msg),
        .in_domain      (in_domain),
        .reqs_p0        (reqs_p0),
        .reqs_p1        (reqs_p1),
        .reqs_p2        (reqs_p2),
        .reqs_p0_domain (reqs_p0_domain),
        .reqs_p1_domain (reqs_p1_domain),
        .reqs_p2_domain (reqs_p2_domain),
        .grants_p0      (grants[0]),
        .grants_p1      (grants[1]),
        .grants_p2      (grants[2]),
        .head_msg       (head_msg),
        .head_domain    (head_domain),
        .term_domain    (term_domain),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [MSG_W-1:0] make_msg(input logic [1:0] dest, input logic [39:0] payload);
        logic [MSG_W-1:0] m;
        m = '0;
        m[41:40] = dest;
        m[39:0]  = payload;
        return m;
    endfunction

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Sample at the falling edge, then return to just after the next rising edge.
    task automatic expect_out(input string name, input logic [2:0] reqs_e, input logic dom_e,
                              input logic rdy_e, input logic [7:0] drop_e);
        @(negedge clk);
        check({name, ".reqs"},   {61'd0, reqs_p2, reqs_p1, reqs_p0}, {61'd0, reqs_e});
        check({name, ".dom"},    {61'd0, reqs_p2_domain, reqs_p1_domain, reqs_p0_domain},
              {61'd0, dom_e, dom_e, dom_e});
        check({name, ".in_rdy"}, {63'd0, in_rdy}, {63'd0, rdy_e});
        check({name, ".drops"},  {56'd0, drop_count}, {56'd0, drop_e});
        @(posedge clk);
        #1;
    endtask

    // Offer one message for one cycle; optionally record its expected delivery.
    task automatic send(input logic [1:0] dest, input logic dom, input logic [39:0] payload,
                        input logic [1:0] port, input logic push);
        exp_t e;
        in_val    = 1'b1;
        in_msg    = make_msg(dest, payload);
        in_domain = dom;
        if (push) begin
            e.port = port;
            e.dom  = dom;
            e.msg  = in_msg;
            sb_q.push_back(e);
        end
        cyc();
        in_val = 1'b0;
    endtask

    task automatic grant(input logic [1:0] port);
        grants       = 3'b000;
        grants[port] = 1'b1;
        cyc();
        grants = 3'b000;
    endtask

    // Monitor: every granted request must match the oldest expected message.
    always @(negedge clk) begin : monitor
        logic [2:0] hit;
        exp_t       e;
        hit = {reqs_p2, reqs_p1, reqs_p0} & grants;
        if (!reset && hit != 3'b000) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: grant taken on 0x%0h with nothing expected", hit);
            end else begin
                e = sb_q.pop_front();
                check("sb.port",   {61'd0, hit}, {61'd0, 3'b001 << e.port});
                check("sb.msg",    {20'd0, head_msg}, {20'd0, e.msg});
                check("sb.domain", {63'd0, head_domain}, {63'd0, e.dom});
            end
        end
    end

    initial begin
        reset       = 1'b1;
        in_val      = 1'b0;
        in_msg      = '0;
        in_domain   = 1'b0;
        grants      = 3'b000;
        term_domain = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        expect_out("reset", 3'b000, 1'b0, 1'b1, 8'd0);

        // dest 0 -> terminal, then grant drains it
        send(2'd0, 1'b0, 40'hA0, 2'd1, 1'b1);
        expect_out("d0_req", 3'b010, 1'b0, 1'b1, 8'd0);
        grant(2'd1);
        expect_out("d0_done", 3'b000, 1'b0, 1'b1, 8'd0);

        // dest 1 -> east, dest 2 -> east (tie), dest 3 -> west
        send(2'd1, 1'b1, 40'hB1, 2'd2, 1'b1);
        expect_out("d1_req", 3'b100, 1'b1, 1'b1, 8'd0);
        grant(2'd2);
        send(2'd2, 1'b0, 40'hB2, 2'd2, 1'b1);
        expect_out("d2_req", 3'b100, 1'b0, 1'b1, 8'd0);
        grant(2'd2);
        send(2'd3, 1'b1, 40'hB3, 2'd0, 1'b1);
        expect_out("d3_req", 3'b001, 1'b1, 1'b1, 8'd0);
        grant(2'd0);
        expect_out("d3_done", 3'b000, 1'b0, 1'b1, 8'd0);

        // Full queue: request held with stray grants on other ports ignored
        send(2'd3, 1'b0, 40'hC1, 2'd0, 1'b1);
        send(2'd1, 1'b1, 40'hC2, 2'd2, 1'b1);
        grants = 3'b110;
        for (int i = 0; i < 10; i++) begin
            expect_out("full_hold", 3'b001, 1'b0, 1'b0, 8'd0);
        end
        grant(2'd0);
        expect_out("full_next", 3'b100, 1'b1, 1'b1, 8'd0);
        grant(2'd2);
        expect_out("full_done", 3'b000, 1'b0, 1'b1, 8'd0);

        // Reset while full discards both entries
        send(2'd0, 1'b0, 40'hD1, 2'd1, 1'b0);
        send(2'd3, 1'b0, 40'hD2, 2'd0, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        expect_out("mid_reset", 3'b000, 1'b0, 1'b1, 8'd0);

        // Simultaneous enqueue and dequeue at count 1
        send(2'd0, 1'b0, 40'hE1, 2'd1, 1'b1);
        begin
            exp_t e;
            in_val    = 1'b1;
            in_msg    = make_msg(2'd3, 40'hE2);
            in_domain = 1'b1;
            e.port = 2'd0;
            e.dom  = 1'b1;
            e.msg  = in_msg;
            sb_q.push_back(e);
            grants = 3'b010;
            cyc();
            in_val = 1'b0;
            grants = 3'b000;
        end
        expect_out("simul_next", 3'b001, 1'b1, 1'b1, 8'd0);
        grant(2'd0);
        expect_out("simul_done", 3'b000, 1'b0, 1'b1, 8'd0);

        // Secure message to a terminal open to domain 0 only
        term_domain = 1'b0;
`ifdef PLAB4_NET_ROUTER_IN_DOMAIN_CHECK_EN
        send(2'd0, 1'b1, 40'hF1, 2'd1, 1'b0);
        expect_out("drop_head", 3'b000, 1'b1, 1'b1, 8'd0);
        expect_out("drop_done", 3'b000, 1'b0, 1'b1, 8'd1);
`else
        send(2'd0, 1'b1, 40'hF1, 2'd1, 1'b1);
        expect_out("nodrop_req", 3'b010, 1'b1, 1'b1, 8'd0);
        grant(2'd1);
        expect_out("nodrop_done", 3'b000, 1'b0, 1'b1, 8'd0);
`endif

        // Terminal open to domain 1: secure message is requested normally
        term_domain = 1'b1;
        send(2'd0, 1'b1, 40'hF2, 2'd1, 1'b1);
`ifdef PLAB4_NET_ROUTER_IN_DOMAIN_CHECK_EN
        expect_out("term_ok_req", 3'b010, 1'b1, 1'b1, 8'd1);
`else
        expect_out("term_ok_req", 3'b010, 1'b1, 1'b1, 8'd0);
`endif
        grant(2'd1);
        @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/plab4_net_router_input_ctrl_sep.md
PLAB4_NET_ROUTER_INPUT_CTRL_SEP -- requirements
Module: plab4_net_router_input_ctrl_sep

Interface
REQ-001 SHALL have parameter p_msg_nbits, default 44, message width in bits.
REQ-002 SHALL have parameter p_dest_lsb, default 40, LSB of the 2-bit destination field in the message.
REQ-003 SHALL have parameter p_router_id, default 0, id of this router.
REQ-004 SHALL have parameter p_num_routers, default 4, ring size; legal range 2..4.
REQ-005 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have ports in_val (input, 1), in_rdy (output, 1), in_msg (input, p_msg_nbits) and in_domain (input, 1): upstream message, valid/ready handshake and security domain.
REQ-008 SHALL have ports reqs_p0, reqs_p1, reqs_p2 (output, 1 each): route requests to west, terminal and east output controls.
REQ-009 SHALL have ports reqs_p0_domain, reqs_p1_domain, reqs_p2_domain (output, 1 each): domain of the head message, one per request wire.
REQ-010 SHALL have ports grants_p0, grants_p1, grants_p2 (input, 1 each): grant from the matching output control.
REQ-011 SHALL have ports head_msg (output, p_msg_nbits) and head_domain (output, 1): head entry, driven to the crossbar.
REQ-012 SHALL have port term_domain (input, 1): domain currently permitted at the terminal port.
REQ-013 SHALL have port drop_count (output, 8): messages dropped by the domain check (REQ-028).

Function
REQ-014 SHALL buffer messages in a 2-entry FIFO of {msg, domain}, with head pointer, tail pointer and a 2-bit count.
REQ-015 SHALL drive in_rdy = (count < 2); no bypass, so in_rdy is 0 while full even if the head dequeues in the same cycle.
REQ-016 SHALL enqueue on in_val && in_rdy; the entry is visible at the head at the earliest in the next cycle (1-cycle latency).
REQ-017 SHALL compute fwd = (dest - p_router_id) mod p_num_routers from the head entry.
REQ-018 SHALL route fwd == 0 to p1, 0 < fwd <= p_num_routers/2 to p2 (ties go east), and otherwise to p0.
REQ-019 SHALL assert exactly one reqs_pX, only when count > 0 and the head is not being dropped; all reqs are 0 when the FIFO is empty.
REQ-020 SHALL drive all three reqs_pX_domain = head_domain, and 0 when the FIFO is empty.
REQ-021 SHALL hold a request stable until it is granted; route and head do not change while waiting.
REQ-022 SHALL dequeue on the clock edge where reqs_pX && grants_pX for the routed port; grants on non-requested ports SHALL be ignored.
REQ-023 SHALL allow a simultaneous enqueue and dequeue when count == 1, leaving count at 1.
REQ-024 SHALL wrap both pointers modulo 2.

Reset
REQ-025 SHALL, while reset is high, clear the pointers, count and drop_count; in_rdy SHALL read 1 and all reqs 0 in the cycle after reset.
REQ-026 SHALL discard buffered messages when reset is asserted mid-operation, with no request issued in the following cycle.
REQ-027 SHALL give reset priority over simultaneous enqueue, dequeue and drop.

Configuration
REQ-028 SHALL implement macro PLAB4_NET_ROUTER_IN_DOMAIN_CHECK_EN; when defined, a head routed to p1 with head_domain=1 and term_domain=0 is dequeued in one cycle without a request, and drop_count increments, saturating at 255.
REQ-029 SHALL, without that macro, never drop messages, tie drop_count to 0 and ignore term_domain.

Structure
REQ-030 SHALL place the port-index constants (WEST=0, TERM=1, EAST=2) and the route function in the shared package plab4_net_pkg.
REQ-031 SHALL implement the FIFO as sub-module plab4_net_InputQueue2 (2-entry, registered, no bypass); route, request and drop logic stay in this module.

Verification
REQ-032 SHALL cover, with id=0 and N=4: send dest=0 -> reqs_p1=1 the next cycle; grants_p1=1 -> reqs_p1=0 the following cycle and in_rdy=1.
REQ-033 SHALL cover dest=1 -> p2, dest=2 -> p2 (tie), dest=3 -> p0, each with reqs_pX_domain equal to the sent in_domain.
REQ-034 SHALL cover: enqueue 2 messages with no grants -> in_rdy=0 and the request held for 10 cycles; 1 grant -> second message requested the next cycle.
REQ-035 SHALL cover: assert reset while count=2 -> next cycle all reqs 0, in_rdy=1, drop_count=0.
REQ-036 SHALL cover, with macro defined: dest=0, in_domain=1, term_domain=0 -> no request, drop_count 0->1; same stimulus without macro -> reqs_p1=1.
REQ-037 SHALL cover: count=1 with a simultaneous grant and in_val -> count stays 1 and the new head is requested the next cycle.
